// File: rtl/stream_pair_packer.sv
// stream_pair_packer
// Pops tokens from an input FIFO and packs consecutive data elements in pairs
// into double-width output words. An input token with its MSB set closes the
// transfer: a dangling single element is zero-padded into a final data word,
// then a close word (MSB set, zero payload) is pushed and the block reports
// done for one cycle. Block-level start/idle/done/ready follow the usual
// ap_ctrl handshake.
module stream_pair_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [DATA_WIDTH:0]     in_s_dout,
  input  logic                    in_s_empty_n,
  output logic                    in_s_read,
  output logic [2*DATA_WIDTH:0]   out_din,
  input  logic                    out_full_n,
  output logic                    out_write,
  output logic [63:0]             count,
  output logic                    odd
);

  localparam int WORD_W = 2 * DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    EMIT,
    CLOSE,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [63:0]             count_q, count_d;
  logic                    odd_q, odd_d;
  logic                    pendingClose_q, pendingClose_d;
  logic [DATA_WIDTH-1:0]   loReg_q, loReg_d;
  logic [WORD_W-1:0]       word_q, word_d;

  logic                    headIsClose;
  logic [DATA_WIDTH-1:0]   headPayload;

  assign headIsClose = in_s_dout[DATA_WIDTH];
  assign headPayload = in_s_dout[DATA_WIDTH-1:0];

  assign count = count_q;
  assign odd   = odd_q;

  // State and datapath registers; reset drops any partial pair or pending word.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      odd_q          <= 1'b0;
      pendingClose_q <= 1'b0;
      loReg_q        <= '0;
      word_q         <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      odd_q          <= odd_d;
      pendingClose_q <= pendingClose_d;
      loReg_q        <= loReg_d;
      word_q         <= word_d;
    end
  end

  // Next-state, datapath updates and handshake outputs; reset forces quiet outputs.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    odd_d          = odd_q;
    pendingClose_d = pendingClose_q;
    loReg_d        = loReg_q;
    word_d         = word_q;
    in_s_read      = 1'b0;
    out_write      = 1'b0;
    out_din        = '0;
    ap_idle        = 1'b0;
    ap_done        = 1'b0;
    ap_ready       = 1'b0;

    case (state_q)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          count_d        = '0;
          odd_d          = 1'b0;
          pendingClose_d = 1'b0;
          state_d        = LO;
        end
      end

      LO: begin
        in_s_read = in_s_empty_n;
        if (in_s_empty_n) begin
          if (headIsClose) begin
            state_d = CLOSE;
          end else begin
            loReg_d = headPayload;
            count_d = count_q + 64'd1;
            state_d = HI;
          end
        end
      end

      HI: begin
        in_s_read = in_s_empty_n;
        if (in_s_empty_n) begin
          if (headIsClose) begin
            word_d         = {1'b0, {DATA_WIDTH{1'b0}}, loReg_q};
            odd_d          = 1'b1;
            pendingClose_d = 1'b1;
          end else begin
            word_d  = {1'b0, headPayload, loReg_q};
            count_d = count_q + 64'd1;
          end
          state_d = EMIT;
        end
      end

      EMIT: begin
        out_din   = word_q;
        out_write = out_full_n;
        if (out_full_n) begin
          state_d = pendingClose_q ? CLOSE : LO;
        end
      end

      CLOSE: begin
        out_din   = {1'b1, {(2 * DATA_WIDTH){1'b0}}};
        out_write = out_full_n;
        if (out_full_n) begin
          state_d = DONE;
        end
      end

      DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (ap_rst) begin
      in_s_read = 1'b0;
      out_write = 1'b0;
      out_din   = '0;
      ap_done   = 1'b0;
      ap_ready  = 1'b0;
      ap_idle   = 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_pair_packer.sv
// tb_stream_pair_packer
// Randomised and directed transfers through stream_pair_packer. Expected
// output words and end-of-run count/odd values come from a pairing model and
// are queued when a transfer is issued; a monitor pops and compares them as
// the DUT writes words and pulses ap_done.
module tb_stream_pair_packer;

  localparam int W = 32;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic            ap_start;
  logic            ap_done;
  logic            ap_idle;
  logic            ap_ready;
  logic [W:0]      in_s_dout;
  logic            in_s_empty_n;
  logic            in_s_read;
  logic [2*W:0]    out_din;
  logic            out_full_n;
  logic            out_write;
  logic [63:0]     count;
  logic            odd;

  logic [W:0]      inQ[$];
  logic [2*W:0]    expQ[$];
  logic [64:0]     doneQ[$];
  logic [W-1:0]    curElems[$];

  int tests = 0;
  int fails = 0;
  int doneSeen = 0;
  bit randEmpty = 1'b1;
  bit randFull = 1'b1;
  bit fullForce = 1'b1;

  stream_pair_packer #(.DATA_WIDTH(W)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .in_s_dout    (in_s_dout),
    .in_s_empty_n (in_s_empty_n),
    .in_s_read    (in_s_read),
    .out_din      (out_din),
    .out_full_n   (out_full_n),
    .out_write    (out_write),
    .count        (count),
    .odd          (odd)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Queue a transfer: data tokens (and optionally a close token carrying junk payload),
  // plus the model's expected words and end-of-run count/odd.
  task automatic applyStimulus(input bit withClose);
    int n;
    n = curElems.size();
    foreach (curElems[i]) inQ.push_back({1'b0, curElems[i]});
    if (withClose) begin
      inQ.push_back({1'b1, W'($urandom)});
      for (int i = 0; i < n; i += 2) begin
        if (i + 1 < n) expQ.push_back({1'b0, curElems[i+1], curElems[i]});
        else           expQ.push_back({1'b0, {W{1'b0}}, curElems[i]});
      end
      expQ.push_back({1'b1, {(2*W){1'b0}}});
      doneQ.push_back({n[0], 64'(n)});
    end
  endtask

  task automatic randomElems(input int n);
    curElems.delete();
    for (int i = 0; i < n; i++) curElems.push_back(W'($urandom));
  endtask

  task automatic startPulse();
    int budget;
    budget = 200;
    while (!ap_idle && budget > 0) begin
      @(negedge ap_clk);
      budget--;
    end
    checkOutput("idle_before_start", ap_idle, 1);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budgetIn);
    int budget;
    budget = budgetIn;
    while (doneSeen < target && budget > 0) begin
      @(negedge ap_clk);
      #1;
      budget--;
    end
    checkOutput("done_timeout", doneSeen >= target, 1);
  endtask

  // Input FIFO and output backpressure model.
  initial begin
    bit fireIn;
    forever begin
      @(negedge ap_clk);
      fireIn = in_s_read && in_s_empty_n;
      @(posedge ap_clk);
      #1;
      if (fireIn && inQ.size() > 0) void'(inQ.pop_front());
      if (inQ.size() > 0 && (!randEmpty || $urandom_range(0, 3) != 0)) begin
        in_s_empty_n = 1'b1;
        in_s_dout    = inQ[0];
      end else begin
        in_s_empty_n = 1'b0;
        in_s_dout    = '0;
      end
      out_full_n = randFull ? ($urandom_range(0, 3) != 0) : fullForce;
    end
  end

  // Monitor: scoreboard comparison of written words and done-time results.
  initial begin
    logic [2*W:0] prevDin;
    logic [2*W:0] expWord;
    logic [64:0]  expDone;
    bit prevStall;
    bit prevDone;
    prevDin = '0;
    prevStall = 1'b0;
    prevDone = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (out_write) begin
        checkOutput("write_needs_space", out_full_n, 1);
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_write: got %h expected no write", out_din);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("out_word", out_din, expWord);
        end
      end
      if (prevStall) checkOutput("stall_stable", out_din, prevDin);
      if (!out_write && out_din != '0) checkOutput("no_pop_while_pending", in_s_read, 0);
      prevStall = !out_write && out_din != '0;
      prevDin = out_din;
      if (ap_done) begin
        checkOutput("ready_with_done", ap_ready, 1);
        checkOutput("done_single_cycle", prevDone, 0);
        if (doneQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_done: got done expected none");
        end else begin
          expDone = doneQ.pop_front();
          checkOutput("count_odd", {odd, count}, expDone);
        end
        doneSeen++;
      end
      prevDone = ap_done;
    end
  end

  initial begin
    logic [2*W:0] hold;
    int budget;
    int target;

    ap_rst = 1'b1;
    ap_start = 1'b0;
    in_s_dout = '0;
    in_s_empty_n = 1'b0;
    out_full_n = 1'b1;

    // Reset state
    repeat (2) @(negedge ap_clk);
    checkOutput("rst_idle", ap_idle, 1);
    checkOutput("rst_read", in_s_read, 0);
    checkOutput("rst_write", out_write, 0);
    checkOutput("rst_done", ap_done, 0);
    checkOutput("rst_ready", ap_ready, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checkOutput("post_rst_count", count, 0);
    checkOutput("post_rst_odd", odd, 0);
    checkOutput("post_rst_idle", ap_idle, 1);

    // Four-element transfer: 0.0, 1.0, 2.0, 3.0
    curElems = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    applyStimulus(1);
    startPulse();
    waitDone(doneSeen + 1, 2000);

    // Five-element transfer: 1.0, 3.0, 5.0, 7.0, 9.0 (last padded)
    curElems = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h40E00000, 32'h41100000};
    applyStimulus(1);
    startPulse();
    waitDone(doneSeen + 1, 2000);

    // Close token only
    curElems.delete();
    applyStimulus(1);
    startPulse();
    waitDone(doneSeen + 1, 2000);

    // Random single runs with random FIFO availability and backpressure
    for (int r = 0; r < 6; r++) begin
      randomElems($urandom_range(0, 7));
      applyStimulus(1);
      startPulse();
      waitDone(doneSeen + 1, 2000);
    end

    // Two back-to-back runs with ap_start held high
    randomElems($urandom_range(1, 7));
    applyStimulus(1);
    randomElems($urandom_range(1, 7));
    applyStimulus(1);
    target = doneSeen + 2;
    @(negedge ap_clk);
    ap_start = 1'b1;
    waitDone(target, 4000);
    ap_start = 1'b0;

    // Directed stall in EMIT
    randEmpty = 1'b0;
    randFull = 1'b0;
    fullForce = 1'b0;
    curElems.delete();
    for (int i = 0; i < 4; i++) curElems.push_back(W'($urandom) | 32'h1);
    applyStimulus(1);
    startPulse();
    budget = 100;
    while (!(out_din != '0 && !out_din[2*W]) && budget > 0) begin
      @(negedge ap_clk);
      budget--;
    end
    checkOutput("reach_emit", budget > 0, 1);
    hold = out_din;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge ap_clk);
      checkOutput("stall_no_write", out_write, 0);
      checkOutput("stall_no_read", in_s_read, 0);
      checkOutput("stall_hold", out_din, hold);
    end
    fullForce = 1'b1;
    @(negedge ap_clk);
    checkOutput("write_on_first_space", out_write, 1);
    waitDone(doneSeen + 1, 2000);
    randFull = 1'b1;

    // Reset while holding one element in HI
    curElems = '{W'($urandom)};
    applyStimulus(0);
    startPulse();
    budget = 100;
    while (inQ.size() != 0 && budget > 0) begin
      @(negedge ap_clk);
      budget--;
    end
    checkOutput("abort_popped", budget > 0, 1);
    @(negedge ap_clk);
    checkOutput("abort_count_before", count, 1);
    ap_rst = 1'b1;
    #1;
    checkOutput("abort_rst_read", in_s_read, 0);
    checkOutput("abort_rst_idle", ap_idle, 1);
    checkOutput("abort_rst_write", out_write, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checkOutput("abort_after_idle", ap_idle, 1);
    checkOutput("abort_after_count", count, 0);
    checkOutput("abort_after_odd", odd, 0);
    checkOutput("abort_after_done", ap_done, 0);
    randEmpty = 1'b1;

    // Fresh run after abort must carry no residue
    randomElems(3);
    applyStimulus(1);
    startPulse();
    waitDone(doneSeen + 1, 2000);

    repeat (5) @(negedge ap_clk);
    checkOutput("exp_words_drained", expQ.size(), 0);
    checkOutput("exp_done_drained", doneQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_pair_packer.md
STREAM_PAIR_PACKER -- requirements
Module: stream_pair_packer

Interface
REQ-001 Parameter: DATA_WIDTH, 32, payload bits per input token (bit DATA_WIDTH is the end-of-transfer flag).
REQ-002 Port: ap_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: ap_rst  in  1  reset, synchronous, active-high.
REQ-004 Port: ap_start  in  1  block-level start; ap_done/ap_idle/ap_ready  out  1 each  block-level status.
REQ-005 Port: in_s_dout  in  DATA_WIDTH+1  input FIFO head (MSB = close token); in_s_empty_n  in  1  head valid; in_s_read  out  1  pop.
REQ-006 Port: out_din  out  2*DATA_WIDTH+1  packed word (MSB = close token, [2W-1:W] = second element, [W-1:0] = first); out_full_n  in  1  space available; out_write  out  1  push.
REQ-007 Port: count  out  64  number of non-close elements consumed in last/current run; odd  out  1  last data word was zero-padded.

Function
REQ-008 FSM states: IDLE, LO, HI, EMIT, CLOSE, DONE.
REQ-009 IDLE: ap_idle=1; ap_start=1 -> count<=0, odd<=0, pending_close<=0, go LO.
REQ-010 LO: in_s_read = in_s_empty_n; on pop with MSB=0 -> lo_reg<=payload, count+1, go HI; on pop with MSB=1 -> go CLOSE.
REQ-011 HI: in_s_read = in_s_empty_n; on pop with MSB=0 -> word<={0,payload,lo_reg}, count+1, go EMIT; on pop with MSB=1 -> word<={0,W'b0,lo_reg}, odd<=1, pending_close<=1, go EMIT.
REQ-012 in_s_read SHALL be 0 in IDLE, EMIT, CLOSE, DONE; payload sampled in the same cycle in_s_read=1.
REQ-013 EMIT: out_din=word, out_write = out_full_n; on write -> CLOSE if pending_close else LO.
REQ-014 CLOSE: out_din={1'b1, 2W'b0}, out_write = out_full_n; on write -> DONE.
REQ-015 DONE: ap_done=1 and ap_ready=1 for exactly one cycle, then IDLE.
REQ-016 out_write SHALL never be 1 when out_full_n=0; out_din SHALL hold stable while stalled.
REQ-017 Outside EMIT/CLOSE out_write=0 and out_din=0.
REQ-018 Latency: second element popped in cycle t -> data word out_write earliest at t+1; close token earliest one cycle after last data word written.
REQ-019 Throughput: one packed word per 3 cycles minimum (LO, HI, EMIT); no input pop while a word is pending.
REQ-020 count wraps modulo 2^64; count and odd hold after DONE until next ap_start accepted in IDLE.
REQ-021 ap_start held high through DONE SHALL start a new run on the IDLE cycle following DONE.
REQ-022 ap_start is ignored in all states except IDLE.

Reset
REQ-023 ap_rst=1 at a rising edge -> state IDLE, count=0, odd=0, pending_close=0, lo_reg=0, word=0, regardless of current state.
REQ-024 During and the cycle after reset: in_s_read=0, out_write=0, ap_done=0, ap_ready=0, ap_idle=1.
REQ-025 Reset mid-run discards partial pair and pending word; no close token emitted for the aborted run.

Verification
REQ-026 Elements 0.0,1.0,2.0,3.0 then close, out_full_n=1 -> words {0,1.0,0.0},{0,3.0,2.0}, then close word, count=4, odd=0, one-cycle ap_done.
REQ-027 Elements 1.0,3.0,5.0,7.0,9.0 then close -> three data words, last {0,0x00000000,9.0}, then close, count=5, odd=1.
REQ-028 Close token only -> single out word with MSB=1 and zero payload, count=0, odd=0.
REQ-029 out_full_n low 3 cycles during EMIT -> out_write=0, out_din stable, in_s_read=0 those cycles; word written on first cycle out_full_n=1.
REQ-030 in_s_empty_n toggled randomly, ap_start held high -> two back-to-back runs, each output sequence correct, ap_done pulses once per run.
REQ-031 ap_rst asserted in HI after one element popped -> outputs at reset values next cycle, new run produces no residue from the aborted pair.
